simon_datapath: RTL and testbench

- Datapath companion to the Simon game control FSM.
- Owns the pattern timer, user timer, score counter, step counter, random-sequence LFSR, switch synchroniser and LED mux.
- Consumes the FSM's enable/reset/select strobes and returns the status flags the FSM branches on.
- Sits between board I/O (4 switches, 4 LEDs) and the FSM.

---
 rtl/simon_datapath.sv | 159 +++++++++++++++
 tb/tb_simon_datapath.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_datapath.sv
// Simon game datapath: timers, score/step counters, sequence LFSR, switch sync and LED mux.
// Optional switch debounce enabled by defining SIMON_DEBOUNCE_EN.
module simon_datapath #(
  parameter int unsigned TIMER_W    = 26,
  parameter int unsigned TIMER_N    = 25000000,
  parameter int unsigned TIMER_MAX  = 50000000,
  parameter int unsigned UTIMER_MAX = 50000000,
  parameter int unsigned SCORE_W    = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               timerCntEn,
  input  logic               timerRst,
  input  logic               uTimerCntEn,
  input  logic               uTimerRst,
  input  logic               scoreCntEn,
  input  logic               scoreCntRst,
  input  logic               seqCntEn,
  input  logic               seqCntRst,
  input  logic               rndSeqEn,
  input  logic               rndSeqRst,
  input  logic               lightAllSl,
  input  logic               lightRndSl,
  input  logic               simonsTurn,
  input  logic [3:0]         switches,
  output logic               timerGtN,
  output logic               timerOut,
  output logic               uTimerOut,
  output logic               seqEqScore,
  output logic               anySwitch,
  output logic               switchMatch,
  output logic [3:0]         leds,
  output logic [SCORE_W-1:0] score
);

  localparam logic [TIMER_W-1:0] T_N   = TIMER_W'(TIMER_N);
  localparam logic [TIMER_W-1:0] T_MAX = TIMER_W'(TIMER_MAX);
  localparam logic [TIMER_W-1:0] U_MAX = TIMER_W'(UTIMER_MAX);
  localparam logic [SCORE_W-1:0] S_MAX = '1;
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0]         SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  if (TIMER_N >= TIMER_MAX || DEB_CYCLES == 0) begin : g_param_check
    $error("simon_datapath: need TIMER_N < TIMER_MAX and DEB_CYCLES > 0");
  end

  logic [TIMER_W-1:0] tcnt_q, tcnt_d;
  logic [TIMER_W-1:0] ucnt_q, ucnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] step_q, step_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [3:0]         sw_meta_q, sw_meta_d;
  logic [3:0]         sw_s_q, sw_s_d;
  logic [3:0]         leds_q, leds_d;
  logic [3:0]         expected;
  logic [3:0]         sw_eff;

  assign expected = 4'b0001 << lfsr_q[1:0];

  always_comb begin
    tcnt_d    = tcnt_q;
    ucnt_d    = ucnt_q;
    score_d   = score_q;
    step_d    = step_q;
    lfsr_d    = lfsr_q;
    sw_meta_d = switches;
    sw_s_d    = sw_meta_q;

    if (timerRst)                            tcnt_d = '0;
    else if (timerCntEn && tcnt_q != T_MAX)  tcnt_d = tcnt_q + TIMER_W'(1);

    if (uTimerRst)                           ucnt_d = '0;
    else if (uTimerCntEn && ucnt_q != U_MAX) ucnt_d = ucnt_q + TIMER_W'(1);

    if (scoreCntRst)                         score_d = '0;
    else if (scoreCntEn && score_q != S_MAX) score_d = score_q + SCORE_W'(1);

    if (seqCntRst)                           step_d = '0;
    else if (seqCntEn && step_q != S_MAX)    step_d = step_q + SCORE_W'(1);

    if (rndSeqRst)     lfsr_d = SEED;
    else if (rndSeqEn) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (lightAllSl)      leds_d = 4'hF;
    else if (lightRndSl) leds_d = expected;
    else if (simonsTurn) leds_d = '0;
    else                 leds_d = sw_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q    <= '0;
      ucnt_q    <= '0;
      score_q   <= '0;
      step_q    <= '0;
      lfsr_q    <= SEED;
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      leds_q    <= '0;
    end else begin
      tcnt_q    <= tcnt_d;
      ucnt_q    <= ucnt_d;
      score_q   <= score_d;
      step_q    <= step_d;
      lfsr_q    <= lfsr_d;
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
      leds_q    <= leds_d;
    end
  end

`ifdef SIMON_DEBOUNCE_EN
  localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [3:0]       deb_q, deb_d;
  logic [DEB_W-1:0] dcnt_q [4];
  logic [DEB_W-1:0] dcnt_d [4];

  // Count consecutive cycles the synchronised bit disagrees with the debounced bit;
  // any agreement restarts the count, and the bit flips on the DEB_CYCLES-th disagreement.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 4; i++) begin
      dcnt_d[i] = '0;
      if (sw_s_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) deb_d[i] = sw_s_q[i];
        else                       dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int unsigned i = 0; i < 4; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign sw_eff = deb_q;
`else
  assign sw_eff = sw_s_q;
`endif

  assign timerGtN    = (tcnt_q > T_N);
  assign timerOut    = (tcnt_q == T_MAX);
  assign uTimerOut   = (ucnt_q == U_MAX);
  assign seqEqScore  = (step_q == score_q);
  assign anySwitch   = |sw_eff;
  assign switchMatch = (sw_eff == expected);
  assign leds        = leds_q;
  assign score       = score_q;

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath: directed scenarios plus randomized run against a reference model.
module tb_simon_datapath;

  localparam int unsigned TN   = 3;
  localparam int unsigned TMAX = 7;
  localparam int unsigned UMAX = 5;
  localparam int unsigned SW   = 4;
  localparam int unsigned DEB  = 4;
  localparam int          SMAX = (1 << SW) - 1;
  localparam logic [7:0]  SEED = 8'hA5;
`ifdef SIMON_DEBOUNCE_EN
  localparam int unsigned SW_LAT = 2 + DEB;
`else
  localparam int unsigned SW_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst, timerCntEn, timerRst, uTimerCntEn, uTimerRst;
  logic scoreCntEn, scoreCntRst, seqCntEn, seqCntRst, rndSeqEn, rndSeqRst;
  logic lightAllSl, lightRndSl, simonsTurn;
  logic [3:0] switches;
  logic timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch;
  logic [3:0] leds;
  logic [SW-1:0] score;

  simon_datapath #(
    .TIMER_W(8), .TIMER_N(TN), .TIMER_MAX(TMAX), .UTIMER_MAX(UMAX),
    .SCORE_W(SW), .LFSR_SEED(SEED), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst),
    .timerCntEn(timerCntEn), .timerRst(timerRst), .uTimerCntEn(uTimerCntEn), .uTimerRst(uTimerRst),
    .scoreCntEn(scoreCntEn), .scoreCntRst(scoreCntRst), .seqCntEn(seqCntEn), .seqCntRst(seqCntRst),
    .rndSeqEn(rndSeqEn), .rndSeqRst(rndSeqRst),
    .lightAllSl(lightAllSl), .lightRndSl(lightRndSl), .simonsTurn(simonsTurn),
    .switches(switches),
    .timerGtN(timerGtN), .timerOut(timerOut), .uTimerOut(uTimerOut),
    .seqEqScore(seqEqScore), .anySwitch(anySwitch), .switchMatch(switchMatch),
    .leds(leds), .score(score)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_tcnt = 0, m_ucnt = 0, m_score = 0, m_step = 0;
  logic [7:0] m_lfsr = SEED;
  logic [3:0] m_s1 = '0, m_s2 = '0, m_leds = '0, m_deb = '0;
  logic [3:0] m_hist [$];

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] onehot(input logic [7:0] l);
    return 4'b0001 << l[1:0];
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [3:0] m_eff();
`ifdef SIMON_DEBOUNCE_EN
    return m_deb;
`else
    return m_s2;
`endif
  endfunction

  // One clock: model advances from pre-edge inputs, outputs sampled 1 time unit after the edge.
  task automatic tick();
    int nt, nu, ns, nq;
    logic [7:0] nl;
    logic [3:0] nled, eff, s_pre;
    logic all_diff;
    eff   = m_eff();
    s_pre = m_s2;
    if (rst) begin
      nt = 0; nu = 0; ns = 0; nq = 0; nl = SEED; nled = '0;
    end else begin
      nt = timerRst    ? 0 : (timerCntEn  ? sat(m_tcnt + 1, TMAX) : m_tcnt);
      nu = uTimerRst   ? 0 : (uTimerCntEn ? sat(m_ucnt + 1, UMAX) : m_ucnt);
      ns = scoreCntRst ? 0 : (scoreCntEn  ? sat(m_score + 1, SMAX) : m_score);
      nq = seqCntRst   ? 0 : (seqCntEn    ? sat(m_step + 1, SMAX)  : m_step);
      nl = rndSeqRst ? SEED : (rndSeqEn ? lfsr_next(m_lfsr) : m_lfsr);
      if (lightAllSl)      nled = 4'hF;
      else if (lightRndSl) nled = onehot(m_lfsr);
      else if (simonsTurn) nled = 4'h0;
      else                 nled = eff;
    end
    @(posedge clk);
    m_tcnt = nt; m_ucnt = nu; m_score = ns; m_step = nq; m_lfsr = nl; m_leds = nled;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      m_hist.delete();
    end else begin
      m_s2 = m_s1;
      m_s1 = switches;
      m_hist.push_back(s_pre);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
`ifdef SIMON_DEBOUNCE_EN
      if (m_hist.size() == DEB) begin
        for (int b = 0; b < 4; b++) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
          if (all_diff) m_deb[b] = ~m_deb[b];
        end
      end
`endif
    end
    #1;
  endtask

  task automatic idle();
    {timerCntEn, timerRst, uTimerCntEn, uTimerRst} = '0;
    {scoreCntEn, scoreCntRst, seqCntEn, seqCntRst, rndSeqEn, rndSeqRst} = '0;
    {lightAllSl, lightRndSl, simonsTurn} = '0;
  endtask

  task automatic do_reset();
    idle();
    switches = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    switches = '0;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch} !== 6'b000100) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000100",
               {timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch});
    end
    total++;
    if (leds !== 4'h0) begin bad++; $display("FAIL reset_leds: got %h want 0", leds); end
    total++;
    if (score !== '0) begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
    rst = 1'b0;
  endtask

  task automatic test_timers();
    int t;
    do_reset();
    timerCntEn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      t = sat(i, TMAX);
      total++;
      if ({timerGtN, timerOut} !== {(t > TN), (t == TMAX)}) begin
        bad++;
        $display("FAIL timer_run[%0d]: got gtN=%b out=%b want gtN=%b out=%b",
                 i, timerGtN, timerOut, (t > TN), (t == TMAX));
      end
    end
    timerRst = 1'b1;
    tick();
    total++;
    if ({timerGtN, timerOut} !== 2'b00) begin
      bad++; $display("FAIL timer_rst_prio: got gtN=%b out=%b want 0 0", timerGtN, timerOut);
    end
    idle();
    uTimerCntEn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (uTimerOut !== (sat(i, UMAX) == UMAX)) begin
        bad++; $display("FAIL utimer_run[%0d]: got %b want %b", i, uTimerOut, (sat(i, UMAX) == UMAX));
      end
    end
    uTimerRst = 1'b1;
    tick();
    total++;
    if (uTimerOut !== 1'b0) begin bad++; $display("FAIL utimer_rst_prio: got %b want 0", uTimerOut); end
    idle();
  endtask

  task automatic test_lfsr();
    logic [3:0] exp_steps [3];
    exp_steps = '{4'b0100, 4'b0010, 4'b0100};
    do_reset();
    lightRndSl = 1'b1;
    tick();
    total++;
    if (leds !== 4'b0010) begin bad++; $display("FAIL lfsr_seed: got %b want 0010", leds); end
    for (int i = 0; i < 3; i++) begin
      rndSeqEn = 1'b1; tick();
      rndSeqEn = 1'b0; tick();
      total++;
      if (leds !== exp_steps[i]) begin
        bad++; $display("FAIL lfsr_step[%0d]: got %b want %b", i, leds, exp_steps[i]);
      end
    end
    rndSeqEn = 1'b1; rndSeqRst = 1'b1; tick();
    rndSeqEn = 1'b0; rndSeqRst = 1'b0; tick();
    total++;
    if (leds !== 4'b0010) begin bad++; $display("FAIL lfsr_reload: got %b want 0010", leds); end
    rndSeqEn = 1'b1; tick();
    rndSeqEn = 1'b0; tick();
    total++;
    if (leds !== 4'b0100) begin bad++; $display("FAIL lfsr_replay: got %b want 0100", leds); end
    idle();
  endtask

  task automatic test_counters();
    do_reset();
    scoreCntEn = 1'b1;
    repeat (20) tick();
    scoreCntEn = 1'b0;
    total++;
    if (score !== 4'd15) begin bad++; $display("FAIL score_sat: got %0d want 15", score); end
    total++;
    if (seqEqScore !== 1'b0) begin bad++; $display("FAIL seq_ne_score: got %b want 0", seqEqScore); end
    seqCntEn = 1'b1;
    repeat (14) tick();
    total++;
    if (seqEqScore !== 1'b0) begin bad++; $display("FAIL step14: got %b want 0", seqEqScore); end
    tick();
    seqCntEn = 1'b0;
    total++;
    if (seqEqScore !== 1'b1) begin bad++; $display("FAIL step15_eq: got %b want 1", seqEqScore); end
    scoreCntRst = 1'b1; scoreCntEn = 1'b1;
    tick();
    idle();
    total++;
    if ({score, seqEqScore} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL score_rst: got score=%0d eq=%b want 0 0", score, seqEqScore);
    end
    do_reset();
    scoreCntEn = 1'b1; seqCntEn = 1'b1;
    repeat (3) tick();
    total++;
    if ({score, seqEqScore} !== {4'd3, 1'b1}) begin
      bad++; $display("FAIL simult_en: got score=%0d eq=%b want 3 1", score, seqEqScore);
    end
    seqCntRst = 1'b1;
    tick();
    idle();
    total++;
    if ({score, seqEqScore} !== {4'd4, 1'b0}) begin
      bad++; $display("FAIL seq_rst_prio: got score=%0d eq=%b want 4 0", score, seqEqScore);
    end
  endtask

  task automatic test_switches();
    do_reset();
    switches = 4'b0010;
    repeat (SW_LAT - 1) tick();
    total++;
    if (anySwitch !== 1'b0) begin bad++; $display("FAIL sw_latency: got any=%b want 0", anySwitch); end
    tick();
    total++;
    if ({anySwitch, switchMatch} !== 2'b11) begin
      bad++; $display("FAIL sw_match: got any=%b match=%b want 1 1", anySwitch, switchMatch);
    end
    switches = 4'b0110;
    repeat (SW_LAT) tick();
    total++;
    if ({anySwitch, switchMatch} !== 2'b10) begin
      bad++; $display("FAIL sw_multi: got any=%b match=%b want 1 0", anySwitch, switchMatch);
    end
    switches = 4'b0001;
    repeat (SW_LAT) tick();
    total++;
    if ({anySwitch, switchMatch} !== 2'b10) begin
      bad++; $display("FAIL sw_wrong: got any=%b match=%b want 1 0", anySwitch, switchMatch);
    end
    switches = 4'b0000;
    repeat (SW_LAT) tick();
    total++;
    if ({anySwitch, switchMatch} !== 2'b00) begin
      bad++; $display("FAIL sw_none: got any=%b match=%b want 0 0", anySwitch, switchMatch);
    end
  endtask

  task automatic test_leds();
    do_reset();
    lightAllSl = 1'b1; lightRndSl = 1'b1;
    tick();
    total++;
    if (leds !== 4'hF) begin bad++; $display("FAIL led_all: got %b want 1111", leds); end
    lightAllSl = 1'b0;
    tick();
    total++;
    if (leds !== 4'b0010) begin bad++; $display("FAIL led_rnd: got %b want 0010", leds); end
    lightRndSl = 1'b0; simonsTurn = 1'b1; switches = 4'b1000;
    repeat (SW_LAT + 1) tick();
    total++;
    if (leds !== 4'h0) begin bad++; $display("FAIL led_simon: got %b want 0000", leds); end
    simonsTurn = 1'b0;
    tick();
    total++;
    if (leds !== 4'b1000) begin bad++; $display("FAIL led_echo: got %b want 1000", leds); end
    idle();
  endtask

`ifdef SIMON_DEBOUNCE_EN
  task automatic test_debounce();
    do_reset();
    switches = 4'b0001;
    repeat (DEB - 1) tick();
    switches = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (anySwitch !== 1'b0) begin bad++; $display("FAIL deb_glitch[%0d]: got %b want 0", i, anySwitch); end
    end
    switches = 4'b0001;
    repeat (SW_LAT - 1) tick();
    total++;
    if (anySwitch !== 1'b0) begin bad++; $display("FAIL deb_early: got %b want 0", anySwitch); end
    tick();
    total++;
    if (anySwitch !== 1'b1) begin bad++; $display("FAIL deb_held: got %b want 1", anySwitch); end
    do_reset();
    switches = 4'b0001;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (anySwitch !== 1'b0) begin bad++; $display("FAIL deb_rst: got %b want 0", anySwitch); end
    repeat (SW_LAT - 1) tick();
    total++;
    if (anySwitch !== 1'b0) begin bad++; $display("FAIL deb_rst_early: got %b want 0", anySwitch); end
    tick();
    total++;
    if (anySwitch !== 1'b1) begin bad++; $display("FAIL deb_rst_held: got %b want 1", anySwitch); end
  endtask
`endif

  task automatic test_random();
    logic [5:0] exp_flags;
    logic [3:0] eff;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      timerCntEn  = ($urandom_range(0, 3) != 0);
      timerRst    = ($urandom_range(0, 15) == 0);
      uTimerCntEn = ($urandom_range(0, 3) != 0);
      uTimerRst   = ($urandom_range(0, 11) == 0);
      scoreCntEn  = ($urandom_range(0, 2) == 0);
      scoreCntRst = ($urandom_range(0, 31) == 0);
      seqCntEn    = ($urandom_range(0, 2) == 0);
      seqCntRst   = ($urandom_range(0, 15) == 0);
      rndSeqEn    = ($urandom_range(0, 3) == 0);
      rndSeqRst   = ($urandom_range(0, 23) == 0);
      lightAllSl  = ($urandom_range(0, 7) == 0);
      lightRndSl  = ($urandom_range(0, 3) == 0);
      simonsTurn  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)      switches = onehot(m_lfsr);
      else if ($urandom_range(0, 7) == 0) switches = 4'($urandom_range(0, 15));
      tick();
      eff = m_eff();
      exp_flags = {(m_tcnt > TN), (m_tcnt == TMAX), (m_ucnt == UMAX),
                   (m_step == m_score), (|eff), (eff == onehot(m_lfsr))};
      total++;
      if ({timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch} !== exp_flags) begin
        bad++;
        $display("FAIL rnd_flags[%0d]: got %b want %b", n,
                 {timerGtN, timerOut, uTimerOut, seqEqScore, anySwitch, switchMatch}, exp_flags);
      end
      total++;
      if (leds !== m_leds) begin bad++; $display("FAIL rnd_leds[%0d]: got %b want %b", n, leds, m_leds); end
      total++;
      if (score !== SW'(m_score)) begin
        bad++; $display("FAIL rnd_score[%0d]: got %0d want %0d", n, score, m_score);
      end
    end
    idle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    switches = '0;
    idle();
    #1;
    test_reset();
    test_timers();
    test_lfsr();
    test_counters();
    test_switches();
    test_leds();
`ifdef SIMON_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
